// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW host loader and sequencer: host opcodes,
// loader states, instruction RAM geometry and instruction field positions.
package vliw_pkg;

  localparam logic [1:0] OP_DATA  = 2'd0;
  localparam logic [1:0] OP_BEGIN = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam int HOST_W      = 16;
  localparam int VLIW_DEPTH  = 512;
  localparam int VLIW_WORD_W = 72;

  // Per-slice field LSBs; slice 2 repeats the layout SLICE_W bits higher.
  localparam int SLICE_W        = 25;
  localparam int F_COEF_LSB     = 0;
  localparam int F_COEF_W       = 9;
  localparam int F_STATE_LSB    = 9;
  localparam int F_STATE_W      = 4;
  localparam int F_BITSTREAM_LSB = 13;
  localparam int F_BITSTREAM_W  = 2;
  localparam int F_SD_ADDR_LSB  = 15;
  localparam int F_SD_ADDR_W    = 4;
  localparam int F_STORE_BIT    = 19;
  localparam int F_LOG_BIT      = 20;
  localparam int F_LOG_ADDR_LSB = 21;
  localparam int F_LOG_ADDR_W   = 4;

  function automatic int slice_base(input int slice);
    return (slice - 1) * SLICE_W;
  endfunction

endpackage

// File: rtl/vliw_word_packer.sv
// Gathers host beats into one instruction word; beat k lands at bits
// [16k+15:16k], the last beat only fills whatever width remains.
module vliw_word_packer
  import vliw_pkg::*;
#(
  parameter int WORD_W = 72,
  parameter int BEATS  = 5
) (
  input  logic              clock_200,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [HOST_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              partial,
  output logic              done
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEAT_W-1:0] beat;
  logic [WORD_W-1:0] shreg;

  assign done    = load && (beat == BEAT_W'(BEATS - 1));
  assign partial = (beat != '0);
  assign word    = shreg;

  always_ff @(posedge clock_200) begin
    if (reset) begin
      beat  <= '0;
      shreg <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (load) begin
      for (int i = 0; i < WORD_W; i++) begin
        if ((i / HOST_W) == int'(beat))
          shreg[i] <= data[i % HOST_W];
      end
      beat <= done ? '0 : beat + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/vliw_loader.sv
// Host front end for the VLIW sequencer: packs host beats into instruction
// words, writes them to the instruction RAM and owns run/stop control.
module vliw_loader
  import vliw_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 72,
  parameter int BEATS  = 5
) (
  input  logic              clock_200,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [1:0]        host_op,
  input  logic [HOST_W-1:0] host_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [WORD_W-1:0] write_data,
  output logic              vliw_start,
  output logic [9:0]        loaded_count,
  output logic              error
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic              full;
  logic              accept;
  logic              do_begin, set_err, pk_load, pk_clear;
  logic              pk_partial, pk_done;
  logic [WORD_W-1:0] pk_word;

  assign accept        = host_valid && host_ready;
  assign write_address = ptr;
  assign write_data    = pk_word;

  vliw_word_packer #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS)
  ) u_packer (
    .clock_200 (clock_200),
    .reset     (reset),
    .clear     (pk_clear),
    .load      (pk_load),
    .data      (host_data),
    .word      (pk_word),
    .partial   (pk_partial),
    .done      (pk_done)
  );

  always_comb begin
    state_n  = state;
    do_begin = 1'b0;
    set_err  = 1'b0;
    pk_load  = 1'b0;
    pk_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (host_op)
            OP_BEGIN: begin
              do_begin = 1'b1;
              pk_clear = 1'b1;
              state_n  = ST_LOAD;
            end
            OP_RUN:  state_n = ST_RUN;
            OP_DATA: set_err = 1'b1;
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (accept) begin
          case (host_op)
            OP_DATA: begin
              pk_load = 1'b1;
              if (pk_done)
                state_n = ST_WRITE;
            end
            OP_BEGIN: begin
              do_begin = 1'b1;
              pk_clear = 1'b1;
            end
            OP_RUN: begin
              set_err  = pk_partial;
              pk_clear = 1'b1;
              state_n  = ST_RUN;
            end
            default: begin
              pk_clear = 1'b1;
              state_n  = ST_IDLE;
            end
          endcase
        end
      end
      ST_WRITE: state_n = ST_LOAD;
      ST_RUN: begin
        if (accept) begin
          case (host_op)
            OP_STOP:  state_n = ST_IDLE;
            OP_DATA:  set_err = 1'b1;
            OP_BEGIN: set_err = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_200) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      full         <= 1'b0;
      loaded_count <= '0;
      error        <= 1'b0;
      write_enable <= 1'b0;
      vliw_start   <= 1'b0;
      host_ready   <= 1'b1;
    end else begin
      state        <= state_n;
      host_ready   <= (state_n != ST_WRITE);
      vliw_start   <= (state_n == ST_RUN);
      // Strobe is registered so it coincides with the WRITE cycle itself.
      write_enable <= (state_n == ST_WRITE) && !full;
      if (do_begin) begin
        ptr          <= host_data[ADDR_W-1:0];
        loaded_count <= '0;
        error        <= 1'b0;
        full         <= 1'b0;
      end else if (set_err) begin
        error <= 1'b1;
      end
      if (state == ST_WRITE) begin
        if (!full) begin
          loaded_count <= loaded_count + 10'd1;
          ptr          <= ptr + ADDR_W'(1);
          if (ptr == '1)
            full <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vliw_loader.sv
// Scoreboard bench for vliw_loader: expected RAM writes are queued as words
// are sent and matched against write_enable pulses.
module tb_vliw_loader;
  import vliw_pkg::*;

  logic        clock_200 = 1'b0;
  logic        reset = 1'b1;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [1:0]  host_op = OP_DATA;
  logic [15:0] host_data = '0;
  logic        write_enable;
  logic [8:0]  write_address;
  logic [71:0] write_data;
  logic        vliw_start;
  logic [9:0]  loaded_count;
  logic        error;

  vliw_loader dut (
    .clock_200     (clock_200),
    .reset         (reset),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .host_op       (host_op),
    .host_data     (host_data),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .vliw_start    (vliw_start),
    .loaded_count  (loaded_count),
    .error         (error)
  );

  always #5 clock_200 = ~clock_200;

  typedef struct {
    logic [8:0]  addr;
    logic [71:0] data;
  } wr_t;

  wr_t  sb[$];
  wr_t  exp_wr;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_writes = 0;

  logic [8:0] m_ptr;
  logic       m_full;
  int         m_count;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clock_200) begin
    if (!reset && write_enable === 1'b1) begin
      n_writes++;
      if (sb.size() == 0) begin
        check_eq("unexpected_write", 72'd1, 72'd0);
      end else begin
        exp_wr = sb.pop_front();
        check_eq("write_address", {63'd0, write_address}, {63'd0, exp_wr.addr});
        check_eq("write_data", write_data, exp_wr.data);
      end
    end
  end

  // Entered and left at posedge+1; returns how many edges the transfer took.
  task automatic send(input logic [1:0] op, input logic [15:0] d, output int edges);
    logic acc;
    edges = 0;
    host_valid = 1'b1;
    host_op    = op;
    host_data  = d;
    do begin
      acc = host_ready;
      @(posedge clock_200);
      #1;
      edges++;
    end while (!acc && edges < 20);
    if (!acc) check_eq("accept_timeout", 72'd0, 72'd1);
    host_valid = 1'b0;
    host_op    = OP_DATA;
    host_data  = '0;
  endtask

  task automatic op(input logic [1:0] o, input logic [15:0] d);
    int e;
    send(o, d, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock_200);
      #1;
    end
  endtask

  task automatic begin_load(input logic [8:0] a);
    op(OP_BEGIN, {7'd0, a});
    m_ptr   = a;
    m_full  = 1'b0;
    m_count = 0;
  endtask

  // w packs beats d4..d0; only the low byte of d4 reaches the RAM word.
  task automatic send_word(input logic [79:0] w, output int first_edges);
    int  e;
    logic writes;
    wr_t x;
    writes = !m_full;
    if (writes) begin
      x.addr = m_ptr;
      x.data = w[71:0];
      sb.push_back(x);
      m_count++;
      if (m_ptr == 9'h1FF) m_full = 1'b1;
      m_ptr = m_ptr + 9'd1;
    end
    for (int k = 0; k < 5; k++) begin
      send(OP_DATA, w[16*k +: 16], e);
      if (k == 0) first_edges = e;
    end
    check_eq("ready_low_in_write", {71'd0, host_ready}, 72'd0);
    check_eq("we_in_write", {71'd0, write_enable}, {71'd0, writes});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, {71'd0, write_enable}, 72'd0);
    check_eq({tag, "_start"}, {71'd0, vliw_start}, 72'd0);
    check_eq({tag, "_count"}, {62'd0, loaded_count}, 72'd0);
    check_eq({tag, "_error"}, {71'd0, error}, 72'd0);
    check_eq({tag, "_ready"}, {71'd0, host_ready}, 72'd1);
    check_eq({tag, "_addr"}, {63'd0, write_address}, 72'd0);
    check_eq({tag, "_data"}, write_data, 72'd0);
  endtask

  initial begin
    int e;
    int wr_before;
    logic [79:0] w;
    m_ptr = '0; m_full = 1'b0; m_count = 0;

    reset = 1'b1;
    idle(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(1);

    // Single-word load
    begin_load(9'h000);
    send_word({16'hABCD, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, e);
    check_eq("single_lc_before", {62'd0, loaded_count}, 72'd0);
    idle(1);
    check_eq("single_lc", {62'd0, loaded_count}, 72'd1);
    check_eq("single_written", n_writes, 1);

    // Full program, run, stop
    begin_load(9'h000);
    for (int i = 0; i < 10; i++) begin
      w = {$urandom, $urandom, $urandom};
      send_word(w, e);
      if (i > 0) check_eq("held_beat_edges", e, 2);
    end
    op(OP_RUN, 16'h0);
    check_eq("run_start", {71'd0, vliw_start}, 72'd1);
    check_eq("run_lc", {62'd0, loaded_count}, 72'd10);
    check_eq("run_error", {71'd0, error}, 72'd0);
    op(OP_STOP, 16'h0);
    check_eq("stop_start", {71'd0, vliw_start}, 72'd0);

    // DATA in IDLE
    op(OP_DATA, 16'h1234);
    check_eq("idle_data_error", {71'd0, error}, 72'd1);

    // Partial word then RUN, illegal BEGIN in RUN
    begin_load(9'd5);
    check_eq("begin_clears_error", {71'd0, error}, 72'd0);
    wr_before = n_writes;
    for (int k = 0; k < 3; k++) op(OP_DATA, 16'h5A00 + 16'(k));
    op(OP_RUN, 16'h0);
    check_eq("partial_start", {71'd0, vliw_start}, 72'd1);
    check_eq("partial_error", {71'd0, error}, 72'd1);
    op(OP_BEGIN, 16'd7);
    idle(1);
    check_eq("begin_in_run_start", {71'd0, vliw_start}, 72'd1);
    check_eq("begin_in_run_error", {71'd0, error}, 72'd1);
    check_eq("partial_no_write", n_writes, wr_before);
    op(OP_STOP, 16'h0);
    check_eq("partial_stop", {71'd0, vliw_start}, 72'd0);
    begin_load(9'd0);
    check_eq("begin_after_partial_error", {71'd0, error}, 72'd0);

    // Overflow at the top of the RAM
    begin_load(9'h1FE);
    for (int i = 0; i < 3; i++) begin
      w = {16'h00C0 + 16'(i), 16'hF000 + 16'(i), 16'h0E0E, 16'h0D0D, 16'h0C0C};
      send_word(w, e);
    end
    idle(1);
    check_eq("ovf_lc", {62'd0, loaded_count}, 72'd2);
    check_eq("ovf_error", {71'd0, error}, 72'd1);

    // Reset mid-load
    begin_load(9'd0);
    op(OP_DATA, 16'hDEAD);
    op(OP_DATA, 16'hBEEF);
    reset = 1'b1;
    idle(1);
    check_reset_outputs("midreset");
    reset = 1'b0;
    m_ptr = '0; m_full = 1'b0; m_count = 0;
    begin_load(9'd0);
    send_word({16'h7788, 16'h6666, 16'h5555, 16'h3C3C, 16'h9A9A}, e);
    idle(1);
    check_eq("midreset_lc", {62'd0, loaded_count}, 72'd1);

    idle(3);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vliw_loader.md
# vliw_loader

Host-side front end for the VLIW instruction sequencer. It accepts 16-bit host writes, packs every five data beats into one 72-bit instruction word, and writes it into the sequencer's 512-entry instruction RAM through that block's `write_enable`/`write_address`/`write_data` port. It also owns the run/stop control, driving the sequencer's `vliw_start`.

## Interface
Parameters:
- `ADDR_W`, default 9: instruction RAM address width (512 entries).
- `WORD_W`, default 72: instruction word width.
- `BEATS`, default 5: host beats per instruction word.

Ports:
- `clock_200`  in  1: sole clock, rising edge. One clock; every register is in this domain.
- `reset`  in  1: synchronous, active-high.
- `host_valid`  in  1: host presents an operation this cycle.
- `host_ready`  out  1: loader can accept an operation. A transfer is `host_valid && host_ready` at the clock edge.
- `host_op`  in  2: operation code.
  - 0: DATA.
  - 1: BEGIN (`host_data[8:0]` is the start address).
  - 2: RUN.
  - 3: STOP.
- `host_data`  in  16: payload.
- `write_enable`  out  1: one-cycle instruction RAM write strobe.
- `write_address`  out  ADDR_W: RAM write address.
- `write_data`  out  WORD_W: packed instruction.
- `vliw_start`  out  1: sequencer run enable; level-held while running.
- `loaded_count`  out  10: instructions written since the last BEGIN (0..512).
- `error`  out  1: sticky protocol error.

## Operation
- **States:** IDLE, LOAD, WRITE, RUN.
- **IDLE:**
  - BEGIN: `ptr` ← `host_data[8:0]`, `beat` ← 0, `loaded_count` ← 0, `error` ← 0, full ← 0, go to LOAD.
  - RUN: go to RUN.
  - DATA: dropped, `error` ← 1.
  - STOP: no-op.
- **LOAD:**
  - DATA beat k (0..3) fills `shreg[16k+15:16k]`.
  - Beat 4 fills `shreg[71:64]` from `host_data[7:0]`; `host_data[15:8]` is ignored.
  - After beat 4, go to WRITE and clear `beat`.
- **WRITE:** lasts one cycle.
  - If not full: `write_enable` = 1, `write_address` = `ptr`, `write_data` = `shreg`, `loaded_count` += 1, `ptr` += 1.
  - If `ptr` was 511: set full, and `ptr` wraps to 0 but is not used again.
  - If full: no write, `error` ← 1.
  - Return to LOAD.
  - `host_ready` = 0 in this state only.
- **RUN from LOAD:**
  - If `beat` ≠ 0, the partial word is discarded and `error` ← 1.
  - Go to RUN either way.
- **BEGIN in LOAD:** restarts the load, with the same effect as BEGIN in IDLE.
- **STOP in LOAD:** go to IDLE; the partial word is discarded with no error.
- **RUN state:** `vliw_start` = 1.
  - STOP: go to IDLE.
  - DATA or BEGIN: dropped, `error` ← 1.
  - RUN: no-op.
- **Error clearing:** `error` clears only on reset or on an accepted BEGIN.
- **Reset:** state IDLE. Every output is 0 except `host_ready` = 1. `ptr`, `beat` and `shreg` are cleared.
  - Reset mid-load discards the partial word.
  - Reset in RUN drops `vliw_start` on the next edge.

## Timing
- All outputs are registered.
- `write_enable` is high exactly the cycle after the 5th beat is accepted.
  - Address, data and `loaded_count` are valid in that same cycle.
  - `loaded_count` is updated on the edge that ends the WRITE cycle.
- An accepted RUN raises `vliw_start` the next cycle; an accepted STOP lowers it the next cycle.
- The sequencer emits `slice_enable` 3 cycles after `vliw_start`.
- **Throughput:** 1 instruction per 6 cycles (5 beats + 1 WRITE) under back-to-back valid.
- **Simultaneous events:** `host_valid` during WRITE is not accepted. The host holds its operation, and it is taken in the following LOAD cycle.
- Writes occur only outside RUN, so the RAM is never written while the sequencer reads it.

## Structure
- Shared package `vliw_pkg`:
  - `host_op` encodings (`OP_DATA`, `OP_BEGIN`, `OP_RUN`, `OP_STOP`).
  - State enum.
  - `VLIW_DEPTH` = 512 and `VLIW_WORD_W` = 72.
  - Instruction field bit positions:
    - slice 1: coefficient [8:0], state [12:9], bitstream [14:13], sigma-delta address [18:15], store [19], log [20], log address [24:21].
    - slice 2: the same fields starting at bit 25.
- One natural sub-module: `vliw_word_packer`, which holds `shreg` and the beat counter and flags a completed word. The control FSM stays in `vliw_loader`.

## Test plan
- **Single-word load:** reset; BEGIN 0x000; DATA 0x1111, 0x2222, 0x3333, 0x4444, 0xABCD → one `write_enable` pulse with address 0, data 0xCD_4444_3333_2222_1111, `loaded_count` = 1.
- **Full program and run:** BEGIN 0; 10 words; RUN → addresses 0..9 written in order; `vliw_start` = 1 the cycle after RUN; STOP → `vliw_start` = 0 the next cycle.
- **Overflow:** BEGIN 0x1FE; 3 words → writes at 0x1FE and 0x1FF; third word not written; `error` = 1; `loaded_count` = 2.
- **Partial word:** BEGIN 5; 3 DATA beats; RUN → no write; `error` = 1; `vliw_start` = 1. A following BEGIN clears `error`.
- **Illegal operations:** DATA in IDLE → `error` = 1. In RUN, BEGIN → dropped, state remains RUN. Hold `host_valid` during WRITE → `host_ready` = 0 for one cycle and the beat is accepted one cycle later.
- **Reset mid-load:** 2 beats; `reset` for one cycle; BEGIN 0; 5 beats → the written word contains only the post-reset beats; all outputs are 0 during reset except `host_ready`.
